// File: rtl/axis_mux_arb.sv
// Frame-aware AXI4-Stream N:1 multiplexer. One input is granted per frame (from sel or
// by round-robin) and held until its tlast beat; the output runs through a main + skid register pair.
module axis_mux_arb #(
  parameter int S_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ARB_MODE    = 0,
  localparam int CL_S       = $clog2(S_COUNT)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [S_COUNT-1:0]             s_axis_tvalid,
  output logic [S_COUNT-1:0]             s_axis_tready,
  input  logic [S_COUNT-1:0]             s_axis_tlast,
  input  logic [S_COUNT*ID_WIDTH-1:0]    s_axis_tid,
  input  logic [S_COUNT*DEST_WIDTH-1:0]  s_axis_tdest,
  input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [ID_WIDTH-1:0]            m_axis_tid,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  input  logic                           enable,
  input  logic [CL_S-1:0]                sel,
  output logic [CL_S-1:0]                cur_src,
  output logic                           busy
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  typedef enum logic [0:0] {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [CL_S-1:0]     cur_src_q, cur_src_d;
  logic [CL_S-1:0]     last_q, last_d;
  logic [S_COUNT-1:0]  tready_q, tready_d;
  logic                m_valid_q, m_valid_d;
  logic                skid_valid_q, skid_valid_d;
  logic                busy_q, busy_d;
  logic [BW-1:0]       main_q, main_d;
  logic [BW-1:0]       skid_q, skid_d;

  logic [DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0] in_keep;
  logic [ID_WIDTH-1:0]   in_id;
  logic [DEST_WIDTH-1:0] in_dest;
  logic [USER_WIDTH-1:0] in_user;
  logic                  in_last;
  logic [BW-1:0]         in_beat;
  logic                  accept;
  logic                  grant;
  logic [CL_S-1:0]       grant_idx;

  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;
  logic                  out_last;

  // Disabled sideband fields are forced here so that nothing stale reaches the registers.
  always_comb begin
    in_data = s_axis_tdata[int'(cur_src_q)*DATA_WIDTH +: DATA_WIDTH];
    in_keep = (KEEP_ENABLE != 0) ? s_axis_tkeep[int'(cur_src_q)*KEEP_WIDTH +: KEEP_WIDTH] : '1;
    in_id   = (ID_ENABLE   != 0) ? s_axis_tid[int'(cur_src_q)*ID_WIDTH +: ID_WIDTH]       : '0;
    in_dest = (DEST_ENABLE != 0) ? s_axis_tdest[int'(cur_src_q)*DEST_WIDTH +: DEST_WIDTH] : '0;
    in_user = (USER_ENABLE != 0) ? s_axis_tuser[int'(cur_src_q)*USER_WIDTH +: USER_WIDTH] : '0;
    in_last = s_axis_tlast[cur_src_q];
    in_beat = {in_last, in_user, in_dest, in_id, in_keep, in_data};
    accept  = tready_q[cur_src_q] & s_axis_tvalid[cur_src_q];
  end

  // Round-robin scans upward from the input after the last grant, wrapping.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    if (ARB_MODE == 0) begin
      if (int'(sel) < S_COUNT && s_axis_tvalid[sel]) begin
        grant     = 1'b1;
        grant_idx = sel;
      end
    end else begin
      for (int i = 1; i <= S_COUNT; i++) begin
        if (!grant && s_axis_tvalid[(int'(last_q) + i) % S_COUNT]) begin
          grant     = 1'b1;
          grant_idx = CL_S'((int'(last_q) + i) % S_COUNT);
        end
      end
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_src_d    = cur_src_q;
    last_d       = last_q;
    m_valid_d    = m_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;

    case (state_q)
      IDLE: begin
        if (enable && grant) begin
          state_d   = ACTIVE;
          cur_src_d = grant_idx;
          last_d    = grant_idx;
        end
      end
      ACTIVE: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (m_axis_tready || !m_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        m_valid_d    = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d    = in_beat;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    // Ready is registered, so it is derived from next-cycle state: open only while skid is empty.
    tready_d = '0;
    if (state_d == ACTIVE && !skid_valid_d) tready_d[cur_src_d] = 1'b1;

    busy_d = (state_d == ACTIVE) | m_valid_d | skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_src_q    <= '0;
      last_q       <= CL_S'(S_COUNT - 1);
      tready_q     <= '0;
      m_valid_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      cur_src_q    <= cur_src_d;
      last_q       <= last_d;
      tready_q     <= tready_d;
      m_valid_q    <= m_valid_d;
      skid_valid_q <= skid_valid_d;
      busy_q       <= busy_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign {out_last, out_user, out_dest, out_id, out_keep, out_data} = main_q;

  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? out_keep : '1;
  assign m_axis_tid    = out_id;
  assign m_axis_tdest  = out_dest;
  assign m_axis_tuser  = out_user;
  assign m_axis_tlast  = out_last;
  assign m_axis_tvalid = m_valid_q;
  assign s_axis_tready = tready_q;
  assign cur_src       = cur_src_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_mux_arb.sv
// Directed bench for axis_mux_arb: a select-mode and a round-robin instance share stimulus,
// a queue scoreboard checks every output transfer, stall stability and ready legality.
module tb_axis_mux_arb;

  localparam int S  = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [S*DW-1:0] s_tdata;
  logic [S-1:0]    s_tkeep  = '1;
  logic [S-1:0]    s_tvalid, s_tlast, s_tuser;
  logic [S*8-1:0]  s_tid    = 32'hDEADBEEF;
  logic [S*8-1:0]  s_tdest  = 32'hCAFEF00D;
  logic            m_tready = 1'b1;
  logic            enable   = 1'b0;
  logic [1:0]      sel      = 2'd0;

  logic [DW-1:0] o_tdata  [2];
  logic [0:0]    o_tkeep  [2];
  logic          o_tvalid [2];
  logic          o_tlast  [2];
  logic [7:0]    o_tid    [2];
  logic [7:0]    o_tdest  [2];
  logic [0:0]    o_tuser  [2];
  logic [S-1:0]  o_sready [2];
  logic [1:0]    o_cur    [2];
  logic          o_busy   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_mux_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .ARB_MODE(g)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(o_sready[g]), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
      .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
      .m_axis_tdata(o_tdata[g]), .m_axis_tkeep(o_tkeep[g]), .m_axis_tvalid(o_tvalid[g]),
      .m_axis_tready(m_tready), .m_axis_tlast(o_tlast[g]), .m_axis_tid(o_tid[g]),
      .m_axis_tdest(o_tdest[g]), .m_axis_tuser(o_tuser[g]),
      .enable(enable), .sel(sel), .cur_src(o_cur[g]), .busy(o_busy[g])
    );
  end

  // Instance under test: 0 = select-driven, 1 = round-robin.
  int dut_sel = 0;
  logic [DW-1:0] m_tdata;
  logic [0:0]    m_tkeep;
  logic          m_tvalid, m_tlast, m_busy;
  logic [7:0]    m_tid, m_tdest;
  logic [0:0]    m_tuser;
  logic [S-1:0]  m_sready;
  logic [1:0]    m_cur;
  assign m_tdata  = o_tdata[dut_sel];
  assign m_tkeep  = o_tkeep[dut_sel];
  assign m_tvalid = o_tvalid[dut_sel];
  assign m_tlast  = o_tlast[dut_sel];
  assign m_tid    = o_tid[dut_sel];
  assign m_tdest  = o_tdest[dut_sel];
  assign m_tuser  = o_tuser[dut_sel];
  assign m_sready = o_sready[dut_sel];
  assign m_cur    = o_cur[dut_sel];
  assign m_busy   = o_busy[dut_sel];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Beat encoding used by sources and scoreboard: {tuser, tlast, tdata}.
  logic [9:0] src_mem [S][64];
  int         src_head [S];
  int         src_tail [S];
  logic [S-1:0] fire_s, last_s, fired, done_s;
  logic [9:0] exp_q[$];
  logic [S-1:0] never_mask = '0;

  function automatic logic [9:0] mk(input int b, input int n, input logic [7:0] base);
    return {1'(b % 2), (b == n - 1), 8'(int'(base) + b)};
  endfunction

  task automatic push_frame(input int src, input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) begin
      src_mem[src][src_tail[src]] = mk(b, n, base);
      src_tail[src]++;
    end
  endtask

  task automatic exp_frame(input logic [7:0] base, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back(mk(b, n, base));
  endtask

  task automatic drive_src();
    for (int i = 0; i < S; i++) begin
      if (src_head[i] < src_tail[i]) begin
        s_tvalid[i]         = 1'b1;
        s_tdata[i*DW +: DW] = src_mem[i][src_head[i]][7:0];
        s_tlast[i]          = src_mem[i][src_head[i]][8];
        s_tuser[i]          = src_mem[i][src_head[i]][9];
      end else begin
        s_tvalid[i]         = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]          = 1'b0;
        s_tuser[i]          = 1'b0;
      end
    end
  endtask

  // Source feeder: retire beats that transferred at the last edge, present the next ones.
  initial begin
    fire_s = '0;
    fired  = '0;
    done_s = '0;
    for (int i = 0; i < S; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    drive_src();
    forever begin
      @(posedge clk);
      #1;
      fired  = fire_s;
      done_s = fire_s & last_s;
      for (int i = 0; i < S; i++) if (fire_s[i]) src_head[i]++;
      fire_s = '0;
      drive_src();
    end
  end

  // Compare process: scoreboard, stall stability, ready legality, sampled mid-cycle.
  logic       hold_v = 1'b0;
  logic [9:0] hold_beat;
  logic [9:0] got_beat;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
      fire_s = '0;
    end else begin
      fire_s   = s_tvalid & m_sready;
      last_s   = s_tlast;
      got_beat = {m_tuser, m_tlast, m_tdata};
      check("tready_only_cur_src", 32'(m_sready & ~(4'b0001 << m_cur)), 32'd0);
      check("tready_never_granted", 32'(m_sready & never_mask), 32'd0);
      if (m_tvalid) check("busy_with_valid", 32'(m_busy), 32'd1);
      if (hold_v) begin
        check("stall_valid_held", 32'(m_tvalid), 32'd1);
        check("stall_fields_stable", 32'(got_beat), 32'(hold_beat));
      end
      if (m_tvalid && m_tready) begin
        check("sb_beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_beat", 32'(got_beat), 32'(exp_q.pop_front()));
      end
      hold_v    = m_tvalid && !m_tready;
      hold_beat = got_beat;
    end
  end

  // Round-robin reference: frames per source, each grant goes to the next requester after the last.
  int plan_cnt [S];
  int plan[$];
  task automatic rr_plan();
    int  last;
    bit  found;
    last = S - 1;
    plan.delete();
    for (int g = 0; g < 64; g++) begin
      found = 1'b0;
      for (int k = 1; k <= S; k++) begin
        if (!found && plan_cnt[(last + k) % S] > 0) begin
          found = 1'b1;
          plan.push_back((last + k) % S);
          plan_cnt[(last + k) % S]--;
          last = (last + k) % S;
        end
      end
    end
  endtask

  function automatic logic [31:0] pack_plan();
    logic [31:0] v = '0;
    foreach (plan[i]) v = (v << 4) | 32'(plan[i]);
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < S; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end
    exp_q.delete();
    fired  = '0;
    done_s = '0;
    drive_src();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    enable     = 1'b0;
    sel        = 2'd0;
    m_tready   = 1'b1;
    never_mask = '0;
    clear_stim();
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_busy) && n < budget) begin
      step(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(m_busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int  fidx [S];
  bit  seen;
  bit  drop_seen;
  logic [3:0] pat;

  initial begin
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;
    s_tdata  = '0;
    step(1);
    check("reset_m_tvalid", 32'(o_tvalid[0] | o_tvalid[1]), 32'd0);
    check("reset_s_tready", 32'(o_sready[0] | o_sready[1]), 32'd0);
    check("reset_busy", 32'(o_busy[0] | o_busy[1]), 32'd0);
    check("reset_tdata", 32'(o_tdata[0] | o_tdata[1]), 32'd0);

    // 1: select mode, input 2 sends A0..A3.
    dut_sel = 0;
    do_reset();
    check("t1_cur_src_reset", 32'(m_cur), 32'd0);
    enable = 1'b1;
    sel    = 2'd2;
    push_frame(2, 8'hA0, 4);
    exp_frame(8'hA0, 4);
    drive_src();
    step(1);
    check("t1_no_output_yet", 32'(m_tvalid), 32'd0);
    check("t1_cur_src", 32'(m_cur), 32'd2);
    check("t1_tready", 32'(m_sready), 32'h4);
    for (int b = 0; b < 4; b++) begin
      step(1);
      check("t1_valid_consecutive", 32'(m_tvalid), 32'd1);
      check("t1_data", 32'(m_tdata), 32'hA0 + 32'(b));
      check("t1_last", 32'(m_tlast), 32'(b == 3));
    end
    check("t1_tkeep_ones", 32'(m_tkeep), 32'd1);
    check("t1_tid_zero", 32'(m_tid), 32'd0);
    check("t1_tdest_zero", 32'(m_tdest), 32'd0);
    wait_drain("t1_drain", 40);

    // 2: sel changes 2->1 mid-frame; input 1 follows once the tlast beat has transferred.
    do_reset();
    enable = 1'b1;
    sel    = 2'd2;
    push_frame(2, 8'hB0, 4);
    push_frame(1, 8'hC0, 2);
    exp_frame(8'hB0, 4);
    exp_frame(8'hC0, 2);
    drive_src();
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step(1);
      if (src_head[2] == 2) sel = 2'd1;
      if (done_s[2]) begin
        seen = 1'b1;
        check("t2_gap_after_tlast", 32'(m_sready), 32'd0);
        step(1);
        check("t2_next_grant_src", 32'(m_cur), 32'd1);
        check("t2_next_grant_ready", 32'(m_sready), 32'h2);
      end
    end
    check("t2_tlast_seen", 32'(seen), 32'd1);
    wait_drain("t2_drain", 40);

    // 3: 8-beat frame under downstream ready pattern 1,0,0,1.
    do_reset();
    enable = 1'b1;
    sel    = 2'd3;
    push_frame(3, 8'h30, 8);
    exp_frame(8'h30, 8);
    drive_src();
    pat       = 4'b1001;
    drop_seen = 1'b0;
    for (int c = 0; c < 80 && (exp_q.size() != 0 || m_busy); c++) begin
      m_tready = pat[c % 4];
      step(1);
      if (src_head[3] > 0 && src_head[3] < 8 && s_tvalid[3] && !m_sready[3]) drop_seen = 1'b1;
    end
    check("t3_tready_dropped", 32'(drop_seen), 32'd1);
    m_tready = 1'b1;
    wait_drain("t3_drain", 40);

    // 4: round-robin among 0,1,3 with two 2-beat frames each; input 2 stays idle.
    dut_sel = 1;
    do_reset();
    never_mask = 4'b0100;
    enable     = 1'b1;
    plan_cnt   = '{2, 2, 0, 2};
    rr_plan();
    check("t4_model_order", pack_plan(), 32'h013013);
    fidx = '{0, 0, 0, 0};
    foreach (plan[i]) begin
      exp_frame(8'(plan[i] * 16 + fidx[plan[i]] * 4), 2);
      fidx[plan[i]]++;
    end
    for (int f = 0; f < 2; f++) begin
      push_frame(0, 8'(0 * 16 + f * 4), 2);
      push_frame(1, 8'(1 * 16 + f * 4), 2);
      push_frame(3, 8'(3 * 16 + f * 4), 2);
    end
    drive_src();
    wait_drain("t4_drain", 200);

    // 5: enable gating, then enable dropped mid-frame.
    dut_sel = 0;
    do_reset();
    sel = 2'd0;
    push_frame(0, 8'h50, 4);
    exp_frame(8'h50, 4);
    drive_src();
    step(3);
    check("t5_disabled_busy", 32'(m_busy), 32'd0);
    check("t5_disabled_valid", 32'(m_tvalid), 32'd0);
    check("t5_disabled_ready", 32'(m_sready), 32'd0);
    enable = 1'b1;
    step(1);
    check("t5_enable_plus1", 32'(m_tvalid), 32'd0);
    step(1);
    check("t5_enable_plus2", 32'(m_tvalid), 32'd1);
    enable = 1'b0;
    wait_drain("t5_drain_after_disable", 40);

    // 6: reset mid-frame, then round-robin restarts from input 0 with single-beat frames.
    dut_sel = 1;
    do_reset();
    enable = 1'b1;
    push_frame(2, 8'h60, 5);
    exp_frame(8'h60, 5);
    drive_src();
    step(3);
    check("t6_midframe_busy", 32'(m_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(m_tvalid), 32'd0);
    check("t6_async_data", 32'(m_tdata), 32'd0);
    check("t6_async_last", 32'(m_tlast), 32'd0);
    check("t6_async_ready", 32'(m_sready), 32'd0);
    check("t6_async_busy", 32'(m_busy), 32'd0);
    check("t6_async_cur", 32'(m_cur), 32'd0);
    clear_stim();
    plan_cnt = '{1, 1, 1, 1};
    rr_plan();
    check("t6_model_order", pack_plan(), 32'h0123);
    foreach (plan[i]) begin
      push_frame(plan[i], 8'(8'h70 + plan[i]), 1);
      exp_frame(8'(8'h70 + plan[i]), 1);
    end
    drive_src();
    step(1);
    rst = 1'b0;
    step(1);
    check("t6_first_grant", 32'(m_cur), 32'd0);
    check("t6_first_ready", 32'(m_sready), 32'h1);
    wait_drain("t6_drain", 60);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
